// File: rtl/adder_vector_checker.sv
// adder_vector_checker: sweeps all eight full-adder input vectors, samples and checks the DUT response.
// Define ADDER_CHK_STOP_ON_ERR_EN to stop the run at the first mismatch.
module adder_vector_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             t_cin,
  output logic             t_a,
  output logic             t_b,
  input  logic             p_s,
  input  logic             p_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fail_vec
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, DONE} state_t;
  state_t           state;
  logic [2:0]       idx;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    pcnt;
  logic             armed;
  logic [1:0]       exp_sum;
  logic             mism;
  logic             stop_now;
  logic             last;
  logic [ERR_W-1:0] err_inc;
  always_comb begin
    exp_sum  = {1'b0, idx[2]} + {1'b0, idx[1]} + {1'b0, idx[0]};
    // case inequality so that X/Z on the DUT response is a mismatch
    mism     = ({p_cout, p_s} !== exp_sum);
    err_inc  = (mism && !(&err_count)) ? err_count + 1'b1 : err_count;
    last     = (idx == 3'd7) && (pcnt == PW'(PASSES - 1));
`ifdef ADDER_CHK_STOP_ON_ERR_EN
    stop_now = mism;
`else
    stop_now = 1'b0;
`endif
  end
  // armed blocks a start pulse landing on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      pcnt      <= '0;
      armed     <= 1'b0;
      {t_cin, t_a, t_b} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE, DONE: if (start && armed) begin
          state     <= LOAD;
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
          err_count <= '0;
          fail_vec  <= '0;
        end
        LOAD: begin
          idx   <= '0;
          cnt   <= '0;
          pcnt  <= '0;
          {t_cin, t_a, t_b} <= 3'b000;
          state <= SETTLE;
        end
        SETTLE: if (cnt == CW'(SETTLE_CYCLES - 1)) state <= CHECK;
                else cnt <= cnt + 1'b1;
        CHECK: begin
          err_count <= err_inc;
          cnt       <= '0;
          if (mism) fail_vec <= idx;
          if (stop_now || last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_inc == '0);
          end else begin
            idx   <= idx + 3'd1;
            {t_cin, t_a, t_b} <= idx + 3'd1;
            if (idx == 3'd7) pcnt <= pcnt + 1'b1;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_vector_checker.sv
// tb_adder_vector_checker: table-driven runs with fault-injected adders and a result scoreboard.
module tb_adder_vector_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0;
  logic t_cin1, t_a1, t_b1, p_s1, p_cout1, busy1, done1, pass1;
  logic t_cin2, t_a2, t_b2, p_s2, p_cout2, busy2, done2, pass2;
  logic [3:0] err1;
  logic [1:0] err2;
  logic [2:0] fv1, fv2;
  int mode = 0;
  bit inst = 1'b0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // fault modes: 0 golden, 1 sum stuck at 0, 2 carry-out inverted
  always_comb begin
    p_s1    = (mode == 1) ? 1'b0 : t_cin1 ^ t_a1 ^ t_b1;
    p_cout1 = ((t_cin1 & t_a1) | (t_cin1 & t_b1) | (t_a1 & t_b1)) ^ (mode == 2);
    p_s2    = (mode == 1) ? 1'b0 : t_cin2 ^ t_a2 ^ t_b2;
    p_cout2 = ((t_cin2 & t_a2) | (t_cin2 & t_b2) | (t_a2 & t_b2)) ^ (mode == 2);
  end

  adder_vector_checker u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .t_cin(t_cin1), .t_a(t_a1), .t_b(t_b1),
    .p_s(p_s1), .p_cout(p_cout1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1));

  adder_vector_checker #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .t_cin(t_cin2), .t_a(t_a2), .t_b(t_b2),
    .p_s(p_s2), .p_cout(p_cout2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fv2));

  logic       o_busy, o_done, o_pass;
  logic [3:0] o_err;
  logic [2:0] o_fv, o_t;
  always_comb begin
    o_busy = inst ? busy2 : busy1;
    o_done = inst ? done2 : done1;
    o_pass = inst ? pass2 : pass1;
    o_err  = inst ? {2'b00, err2} : err1;
    o_fv   = inst ? fv2 : fv1;
    o_t    = inst ? {t_cin2, t_a2, t_b2} : {t_cin1, t_a1, t_b1};
  end

  typedef struct {
    bit         inst;
    int         mode;
    int         err;
    bit         pas;
    logic [2:0] fv;
    int         cyc;
    int         xstart;
  } case_t;

  case_t tbl[6];
  case_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (inst) start2 = v; else start1 = v;
  endtask

  task automatic run_case(input case_t c, input int abort_at, output bit aborted);
    case_t e;
    int n;
    int vec_bad;
    aborted = 1'b0;
    inst = c.inst;
    mode = c.mode;
    exp_q.push_back(c);
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    chk("load_busy", o_busy, 1);
    chk("load_done_clr", o_done, 0);
    chk("load_err_clr", o_err, 0);
    n = 0;
    vec_bad = 0;
    while (!o_done && n < 400) begin
      @(negedge clk);
      n++;
      set_start(n == c.xstart);
      if (n == abort_at) begin
        chk("abort_vec", o_t, ((n - 1) / 3) % 8);
        set_start(1'b0);
        void'(exp_q.pop_front());
        aborted = 1'b1;
        return;
      end
      if (!o_done && o_t !== 3'(((n - 1) / 3) % 8)) vec_bad++;
    end
    set_start(1'b0);
    chk("vector_sweep_errors", vec_bad, 0);
    if (n >= 400) begin
      chk("done_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    chk("run_cycles", n, e.cyc);
    chk("err_count", o_err, e.err);
    chk("pass", o_pass, e.pas);
    chk("fail_vec", o_fv, e.fv);
    chk("busy_in_done", o_busy, 0);
    chk("t_hold", o_t, ((e.cyc - 2) / 3) % 8);
    repeat (2) @(negedge clk);
    chk("done_level", o_done, 1);
  endtask

  initial begin
    bit ab;
    case_t c;
`ifdef ADDER_CHK_STOP_ON_ERR_EN
    tbl[0] = '{1'b0, 0, 0, 1'b1, 3'd0, 25, 10};
    tbl[1] = '{1'b0, 1, 1, 1'b0, 3'd1, 7, 0};
    tbl[2] = '{1'b0, 2, 1, 1'b0, 3'd0, 4, 0};
    tbl[3] = '{1'b1, 2, 1, 1'b0, 3'd0, 4, 0};
    tbl[4] = '{1'b1, 0, 0, 1'b1, 3'd0, 49, 20};
    tbl[5] = '{1'b0, 0, 0, 1'b1, 3'd0, 25, 0};
`else
    tbl[0] = '{1'b0, 0, 0, 1'b1, 3'd0, 25, 10};
    tbl[1] = '{1'b0, 1, 4, 1'b0, 3'd7, 25, 0};
    tbl[2] = '{1'b0, 2, 8, 1'b0, 3'd7, 25, 0};
    tbl[3] = '{1'b1, 2, 3, 1'b0, 3'd7, 49, 0};
    tbl[4] = '{1'b1, 0, 0, 1'b1, 3'd0, 49, 20};
    tbl[5] = '{1'b0, 0, 0, 1'b1, 3'd0, 25, 0};
`endif
    start1 = 1'b1;
    start2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs_u1", {busy1, done1, pass1, err1, fv1, t_cin1, t_a1, t_b1}, 0);
    chk("reset_outputs_u2", {busy2, done2, pass2, err2, fv2, t_cin2, t_a2, t_b2}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    chk("start_at_release_ignored_u1", busy1, 0);
    chk("start_at_release_ignored_u2", busy2, 0);
    @(negedge clk);
    chk("still_idle", {busy1, busy2}, 0);
    for (int i = 0; i < 6; i++) run_case(tbl[i], 0, ab);
    c = '{1'b0, 0, 0, 1'b1, 3'd0, 25, 0};
    run_case(c, 16, ab);
    chk("abort_reached", ab, 1);
    #1 rst_n = 1'b0;
    #1 chk("midrun_reset_outputs", {busy1, done1, pass1, err1, fv1, t_cin1, t_a1, t_b1}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_case(c, 0, ab);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
